// File: rtl/fetch_unit_if.sv
// Fetch-side bus: instruction memory address/data, decode back-pressure,
// branch redirect, and the instruction register handed to decode.
interface fetch_unit_if;
    logic [7:0]  PC;
    logic [15:0] inst;
    logic        stall;
    logic        branch_taken;
    logic [7:0]  branch_target;
    logic [15:0] ir;
    logic [7:0]  ir_pc;
    logic        ir_valid;
    logic        halted;
    logic [15:0] fetch_count;

    // The fetch unit itself
    modport master (
        output PC, ir, ir_pc, ir_valid, halted, fetch_count,
        input  inst, stall, branch_taken, branch_target
    );

    // Instruction memory plus decode stage
    modport slave (
        input  PC, ir, ir_pc, ir_valid, halted, fetch_count,
        output inst, stall, branch_taken, branch_target
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: walks PC through instruction memory, loads the
// instruction register for decode, honours stall and branch redirect, and
// stops permanently on a halt opcode until reset.
//
// state | meaning
// ------+-----------------------------------------------------------
// RUN   | fetching; PC advances on every unstalled, unbranched edge
// HALT  | halt word captured; everything frozen until rst_n
module fetch_unit #(
    parameter logic [7:0] RESET_PC    = 8'h00,
    parameter logic [3:0] HALT_OPCODE = 4'b1000
) (
    input logic           clk,
    input logic           rst_n,
    fetch_unit_if.master  bus
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t      state;
    logic [7:0]  pc;
    logic [15:0] ir;
    logic [7:0]  ir_pc;
    logic        ir_valid;
    logic [15:0] fetch_count;

    // All outputs come straight from registers; no input reaches them combinationally.
    assign bus.PC          = pc;
    assign bus.ir          = ir;
    assign bus.ir_pc       = ir_pc;
    assign bus.ir_valid    = ir_valid;
    assign bus.fetch_count = fetch_count;
    assign bus.halted      = (state == ST_HALT);

    // Fetch FSM: branch beats stall, stall beats capture, halt word stops PC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_RUN;
            pc          <= RESET_PC;
            ir          <= 16'h0000;
            ir_pc       <= 8'h00;
            ir_valid    <= 1'b0;
            fetch_count <= 16'h0000;
        end else begin
            case (state)
                ST_RUN: begin
                    if (bus.branch_taken) begin
                        // Redirect discards whatever word is on inst, halt included.
                        pc       <= bus.branch_target;
                        ir_valid <= 1'b0;
                    end else if (!bus.stall) begin
                        ir       <= bus.inst;
                        ir_pc    <= pc;
                        ir_valid <= 1'b1;
                        if (fetch_count != 16'hFFFF) begin
                            fetch_count <= fetch_count + 16'd1;
                        end
                        if (bus.inst[15:12] == HALT_OPCODE) begin
                            state <= ST_HALT;
                        end else begin
                            pc <= pc + 8'd1;
                        end
                    end
                end
                ST_HALT: begin
                    ir_valid <= 1'b0;
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

endmodule
